text_layer_renderer: RTL and testbench
======================================

Name: text_layer_renderer

Overview:
- Scan-out stage downstream of the text writers: game-over text, score and banners all write into the text RAM.
- Reads the text RAM and an 8x8 font ROM in step with the VGA raster.
- Produces a per-pixel text overlay with colour, plus sync/blank delayed to stay aligned with it.
- Sits between the VGA timing generator and the final colour mux.

Parameters:
COLS, 80, text cells per row (640/8)
ROWS, 60, text rows (480/8)
ADDR_W, 16, text RAM address width
FG_RGB, 12'hFFF, foreground colour for set glyph pixels
PIPE_LAT, 4, pixel-tick latency from raster input to overlay output (fixed; informational)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pixel_tick  in  1  one-clk strobe per pixel; all pipeline stages advance only on it
hcount  in  10  raster x, 0..799
vcount  in  10  raster y, 0..524
video_on  in  1  active-area flag from timing generator
hsync_i  in  1  horizontal sync from timing generator
vsync_i  in  1  vertical sync from timing generator
tram_addr  out  ADDR_W  text RAM read address
tram_dout  in  16  text RAM read data, 1-clk registered latency; cell format {7'b0, visible, 2'b00, glyph[5:0]}
font_addr  out  9  font ROM address {glyph[5:0], glyph_row[2:0]}
font_data  in  8  font ROM row, 1-clk latency; bit 7 = leftmost pixel
text_on  out  1  current pixel is a set glyph pixel
text_rgb  out  12  FG_RGB when text_on, else 12'h000
hsync_o  out  1  hsync_i delayed PIPE_LAT ticks
vsync_o  out  1  vsync_i delayed PIPE_LAT ticks
video_on_o  out  1  video_on delayed PIPE_LAT ticks

Behaviour:
- Reset: asynchronous on rst_n=0. All outputs and pipeline registers clear to 0, including tram_addr, font_addr, text_on, text_rgb and the delayed syncs.
- Reset mid-frame: the pipeline flushes. The first valid output appears PIPE_LAT ticks after the first pixel_tick following release.
- Without pixel_tick, every register holds. The RAM and ROM hold their outputs while their addresses are held.
- Stage 1 (tick):
  - col = hcount[9:3], row = vcount[9:3].
  - tram_addr <= row*COLS + col, computed as (row<<6)+(row<<4)+col for COLS=80; zero-extend to ADDR_W.
  - Register hcount[2:0], vcount[2:0], video_on, the syncs, and an in_grid flag (video_on && col<COLS && row<ROWS).
- Stage 2 (tick): latch tram_dout. font_addr <= {tram_dout[5:0], y[2:0]}. Carry visible = tram_dout[8] && in_grid.
- Stage 3 (tick): latch font_data and carry x[2:0] and visible.
- Stage 4 (tick):
  - text_on <= visible && font_row[7 - x].
  - text_rgb <= text_on_next ? FG_RGB : 0.
  - The delayed syncs and video_on_o update on the same tick.
- Total latency is exactly 4 pixel ticks.
- Blanking: out-of-grid or blanking pixels force text_on=0, even when stale RAM data shows visible=1.
- Cell 4799 (col 79, row 59) is the last addressed cell. No address beyond 4799 is generated during active video.
- Writers may update the RAM mid-frame. A change becomes visible from the next read of that cell, with no tearing protection.

Decomposition:
- Shared package text_pkg:
  - TEXT_COLS, TEXT_ROWS.
  - Cell field positions: CELL_VIS_BIT=8, CELL_GLYPH_MSB=5.
  - GLYPH_W=6, FONT_ROW_W=8.
  - These constants are shared with the text writers.
- One sub-module, sync_delay_line: a WIDTH-parameterised, DEPTH-stage shift register with tick enable and asynchronous reset. It carries hsync, vsync and video_on.

Test Plan:
- Cell 175 = 16'h011C, ROM row 0 of glyph 0x1C = 8'h81, raster at vcount=16, hcount=120..127 -> text_on=1 only for hcount 120 and 127, each appearing 4 ticks later with text_rgb=12'hFFF.
- Cell 175 = 16'h001C (visible=0) -> text_on stays 0 across the whole cell.
- Cell 4799 visible, glyph row = 8'hFF, hcount 632..639, vcount 479 -> 8 consecutive text_on pixels. At hcount 640+ (blank) -> text_on=0 with the syncs aligned.
- pixel_tick every 4th clk with random 1-3 clk gaps -> output sequence identical to the continuous-tick run; no register changes between ticks.
- rst_n asserted mid-line at hcount=300 -> all outputs 0 immediately (asynchronous). After release, the first text_on is no earlier than the 4th tick.
- Sync alignment: hsync_i pulse at hcount 656..751 -> hsync_o pulse shifted exactly 4 ticks with the same width.

Source files
------------

// File: rtl/text_pkg.sv
// Shared text-layer constants: screen grid size and text RAM cell / font ROM field layout.
// The text writers import this package too, so cell format changes happen in one place.
package text_pkg;

    localparam int TEXT_COLS      = 80;
    localparam int TEXT_ROWS      = 60;
    localparam int CELL_VIS_BIT   = 8;
    localparam int CELL_GLYPH_MSB = 5;
    localparam int GLYPH_W        = 6;
    localparam int FONT_ROW_W     = 8;

    typedef logic [GLYPH_W-1:0]    glyph_t;
    typedef logic [FONT_ROW_W-1:0] font_row_t;

    // Bit 7 of a font row is the leftmost pixel of the cell.
    function automatic logic glyph_pixel(input font_row_t row, input logic [2:0] x);
        return row[3'd7 - x];
    endfunction

endpackage

// File: rtl/text_layer_renderer_if.sv
// Raster-in / memory / overlay-out bundle of the text layer renderer.
// master = raster source plus RAM/ROM side, slave = the renderer itself.
interface text_layer_renderer_if #(
    parameter int ADDR_W = 16
);
    logic              pixel_tick;
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic              video_on;
    logic              hsync_i;
    logic              vsync_i;
    logic [ADDR_W-1:0] tram_addr;
    logic [15:0]       tram_dout;
    logic [8:0]        font_addr;
    logic [7:0]        font_data;
    logic              text_on;
    logic [11:0]       text_rgb;
    logic              hsync_o;
    logic              vsync_o;
    logic              video_on_o;

    modport master (
        output pixel_tick, hcount, vcount, video_on, hsync_i, vsync_i,
        output tram_dout, font_data,
        input  tram_addr, font_addr, text_on, text_rgb, hsync_o, vsync_o, video_on_o
    );

    modport slave (
        input  pixel_tick, hcount, vcount, video_on, hsync_i, vsync_i,
        input  tram_dout, font_data,
        output tram_addr, font_addr, text_on, text_rgb, hsync_o, vsync_o, video_on_o
    );

endinterface

// File: rtl/sync_delay_line.sv
// Tick-enabled shift register that keeps sync/blank flags aligned with a pixel pipeline.
module sync_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per tick, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else if (tick) begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/text_layer_renderer.sv
// Four-tick scan-out of the text RAM through the 8x8 font ROM into a per-pixel overlay,
// with sync and blank delayed to match. Strobes need at least one idle clk between them.
module text_layer_renderer
    import text_pkg::*;
#(
    parameter int          COLS     = TEXT_COLS,
    parameter int          ROWS     = TEXT_ROWS,
    parameter int          ADDR_W   = 16,
    parameter logic [11:0] FG_RGB   = 12'hFFF,
    parameter int          PIPE_LAT = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    text_layer_renderer_if.slave bus
);

    localparam logic [6:0] COLS_L = 7'(COLS);
    localparam logic [6:0] ROWS_L = 7'(ROWS);

    logic [6:0]        col_s;
    logic [6:0]        row_s;
    logic              in_grid_s;
    logic [ADDR_W-1:0] addr_next_s;
    glyph_t            glyph_s;
    logic              vis_next_s;
    logic              text_on_next_s;
    logic [2:0]        sync_dly_s;
    logic              unused_cell_bits_s;

    logic [ADDR_W-1:0] tram_addr_r;
    logic [2:0]        x1_r;
    logic [2:0]        y1_r;
    logic              in_grid1_r;
    logic [8:0]        font_addr_r;
    logic [2:0]        x2_r;
    logic              vis2_r;
    font_row_t         font_row3_r;
    logic [2:0]        x3_r;
    logic              vis3_r;
    logic              text_on_r;
    logic [11:0]       text_rgb_r;

    // Cell address, grid test, cell decode and final pixel select.
    always_comb begin
        col_s          = bus.hcount[9:3];
        row_s          = bus.vcount[9:3];
        addr_next_s    = (ADDR_W'(row_s) << 6) + (ADDR_W'(row_s) << 4) + ADDR_W'(col_s);
        in_grid_s      = bus.video_on && (col_s < COLS_L) && (row_s < ROWS_L);
        glyph_s        = bus.tram_dout[CELL_GLYPH_MSB:0];
        vis_next_s     = bus.tram_dout[CELL_VIS_BIT] && in_grid1_r;
        text_on_next_s = vis3_r && glyph_pixel(font_row3_r, x3_r);
    end

    assign unused_cell_bits_s = ^{bus.tram_dout[15:CELL_VIS_BIT+1],
                                  bus.tram_dout[CELL_VIS_BIT-1:CELL_GLYPH_MSB+1]};

    // Pixel pipeline: RAM address, font address, font row, overlay pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tram_addr_r <= {ADDR_W{1'b0}};
            x1_r        <= 3'd0;
            y1_r        <= 3'd0;
            in_grid1_r  <= 1'b0;
            font_addr_r <= 9'd0;
            x2_r        <= 3'd0;
            vis2_r      <= 1'b0;
            font_row3_r <= {FONT_ROW_W{1'b0}};
            x3_r        <= 3'd0;
            vis3_r      <= 1'b0;
            text_on_r   <= 1'b0;
            text_rgb_r  <= 12'h000;
        end else if (bus.pixel_tick) begin
            tram_addr_r <= addr_next_s;
            x1_r        <= bus.hcount[2:0];
            y1_r        <= bus.vcount[2:0];
            in_grid1_r  <= in_grid_s;
            font_addr_r <= {glyph_s, y1_r};
            x2_r        <= x1_r;
            vis2_r      <= vis_next_s;
            font_row3_r <= bus.font_data;
            x3_r        <= x2_r;
            vis3_r      <= vis2_r;
            text_on_r   <= text_on_next_s;
            text_rgb_r  <= text_on_next_s ? FG_RGB : 12'h000;
        end
    end

    sync_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_LAT)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (bus.pixel_tick),
        .din   ({bus.hsync_i, bus.vsync_i, bus.video_on}),
        .dout  (sync_dly_s)
    );

    assign bus.tram_addr  = tram_addr_r;
    assign bus.font_addr  = font_addr_r;
    assign bus.text_on    = text_on_r;
    assign bus.text_rgb   = text_rgb_r;
    assign bus.hsync_o    = sync_dly_s[2];
    assign bus.vsync_o    = sync_dly_s[1];
    assign bus.video_on_o = sync_dly_s[0];

endmodule

// File: tb/tb_text_layer_renderer.sv
// Directed bench for text_layer_renderer: table of raster pixels with hand-computed overlay,
// plus sequences for jittered ticks, mid-frame RAM update, mid-line reset and hsync alignment.
module tb_text_layer_renderer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    text_layer_renderer_if #(.ADDR_W(16)) tif();

    text_layer_renderer #(
        .COLS     (80),
        .ROWS     (60),
        .ADDR_W   (16),
        .FG_RGB   (12'hFFF),
        .PIPE_LAT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif.slave)
    );

    logic [15:0] tram  [0:8191];
    logic [7:0]  fontm [0:511];

    // Registered text RAM and font ROM models, one clk of read latency each.
    always @(posedge clk) begin
        tif.tram_dout <= tram[tif.tram_addr[12:0]];
        tif.font_data <= fontm[tif.font_addr];
    end

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       vid;
        logic       hs;
        logic       vs;
        logic       on;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {23'd0, tif.tram_addr, tif.font_addr, tif.text_on, tif.text_rgb,
                tif.hsync_o, tif.vsync_o, tif.video_on_o};
    endfunction

    function automatic void add(input int h, input int v, input logic vid, input logic hs,
                                input logic vs, input logic on);
        vec_t e;
        e.h = 10'(h); e.v = 10'(v); e.vid = vid; e.hs = hs; e.vs = vs; e.on = on;
        tbl.push_back(e);
    endfunction

    // One pixel strobe, then gap idle clks; optionally check that outputs hold in the gap.
    task automatic step(input logic [9:0] h, input logic [9:0] v, input logic vid,
                        input logic hs, input logic vs, input int gap, input bit hold);
        logic [63:0] snap;
        tif.hcount = h; tif.vcount = v; tif.video_on = vid;
        tif.hsync_i = hs; tif.vsync_i = vs; tif.pixel_tick = 1'b1;
        @(posedge clk); #1;
        tif.pixel_tick = 1'b0;
        snap = out_vec();
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            if (hold) chk("hold_between_ticks", out_vec(), snap);
        end
    endtask

    task automatic chk_out(input string tag, input logic on, input logic hs,
                           input logic vs, input logic vid);
        chk({tag, ".text_on"},    64'(tif.text_on),    64'(on));
        chk({tag, ".text_rgb"},   64'(tif.text_rgb),   on ? 64'h0FFF : 64'h0000);
        chk({tag, ".hsync_o"},    64'(tif.hsync_o),    64'(hs));
        chk({tag, ".vsync_o"},    64'(tif.vsync_o),    64'(vs));
        chk({tag, ".video_on_o"}, 64'(tif.video_on_o), 64'(vid));
    endtask

    task automatic run_table(input string tag, input bit jitter);
        int n;
        int gap;
        n = tbl.size();
        for (int k = 0; k < n + 3; k++) begin
            gap = jitter ? int'($urandom_range(1, 3)) : 3;
            if (k < n) step(tbl[k].h, tbl[k].v, tbl[k].vid, tbl[k].hs, tbl[k].vs, gap, jitter);
            else       step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, gap, jitter);
            if (k >= 3)
                chk_out($sformatf("%s[%0d]", tag, k - 3), tbl[k-3].on, tbl[k-3].hs,
                        tbl[k-3].vs, tbl[k-3].vid);
        end
    endtask

    initial begin
        int lows;
        logic hs_exp [$];

        for (int i = 0; i < 8192; i++) tram[i] = 16'h0000;
        for (int i = 0; i < 512; i++)  fontm[i] = 8'h00;
        tram[175]  = 16'h011C;                    // row 2, col 15, glyph 0x1C visible
        tram[4799] = 16'h0105;                    // last cell, glyph 0x05 visible
        tram[4800] = 16'h0105;                    // just past the grid: must never show
        fontm[{6'h1C, 3'd0}] = 8'h81;
        for (int r = 0; r < 8; r++) fontm[{6'h05, 3'(r)}] = 8'hFF;

        tif.pixel_tick = 1'b0; tif.hcount = 10'd0; tif.vcount = 10'd0;
        tif.video_on = 1'b0; tif.hsync_i = 1'b1; tif.vsync_i = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset.tram_addr",  64'(tif.tram_addr),  64'd0);
        chk("reset.font_addr",  64'(tif.font_addr),  64'd0);
        chk("reset.text_on",    64'(tif.text_on),    64'd0);
        chk("reset.text_rgb",   64'(tif.text_rgb),   64'd0);
        chk("reset.hsync_o",    64'(tif.hsync_o),    64'd0);
        chk("reset.vsync_o",    64'(tif.vsync_o),    64'd0);
        chk("reset.video_on_o", 64'(tif.video_on_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cell 175, glyph row 8'h81: only the leftmost and rightmost pixels are set.
        for (int h = 120; h < 128; h++) add(h, 16, 1'b1, 1'b1, 1'b1, (h == 120) || (h == 127));
        // Cell 4799, row 7 = 8'hFF: eight consecutive pixels.
        for (int h = 632; h < 640; h++) add(h, 479, 1'b1, 1'b1, 1'b1, 1'b1);
        add(640, 479, 1'b0, 1'b1, 1'b1, 1'b0);   // horizontal blank
        add(641, 479, 1'b0, 1'b1, 1'b1, 1'b0);
        add(640, 479, 1'b1, 1'b1, 1'b1, 1'b0);   // col 80, stale visible cell 4800
        add(0,   480, 1'b1, 1'b1, 1'b1, 1'b0);   // row 60, stale visible cell 4800
        add(120, 16,  1'b0, 1'b1, 1'b1, 1'b0);   // blanked inside the grid
        add(100, 490, 1'b0, 1'b1, 1'b0, 1'b0);   // vsync active
        add(656, 100, 1'b0, 1'b0, 1'b1, 1'b0);   // hsync active

        run_table("cont", 1'b0);
        run_table("jitter", 1'b1);

        // Stage addresses for the last cell.
        step(10'd639, 10'd479, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        chk("addr.last_cell", 64'(tif.tram_addr), 64'd4799);
        step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        chk("addr.last_font", 64'(tif.font_addr), 64'd47);
        step(10'd120, 10'd16, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        chk("addr.cell175", 64'(tif.tram_addr), 64'd175);

        // Writer clears the visible bit mid-frame: whole cell stays dark.
        tram[175] = 16'h001C;
        for (int k = 0; k < 11; k++) begin
            if (k < 8) step(10'(120 + k), 10'd16, 1'b1, 1'b1, 1'b1, 3, 1'b0);
            else       step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
            if (k >= 3) chk_out($sformatf("invis[%0d]", k - 3), 1'b0, 1'b1, 1'b1, 1'b1);
        end
        tram[175] = 16'h011C;

        // Fill the pipeline with lit pixels, then reset mid-line.
        for (int k = 0; k < 5; k++) step(10'd120, 10'd16, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        chk("pre_reset.text_on", 64'(tif.text_on), 64'd1);
        tif.hcount = 10'd300;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset.text_on",    64'(tif.text_on),    64'd0);
        chk("midreset.text_rgb",   64'(tif.text_rgb),   64'd0);
        chk("midreset.tram_addr",  64'(tif.tram_addr),  64'd0);
        chk("midreset.font_addr",  64'(tif.font_addr),  64'd0);
        chk("midreset.hsync_o",    64'(tif.hsync_o),    64'd0);
        chk("midreset.video_on_o", 64'(tif.video_on_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(10'd120, 10'd16, 1'b1, 1'b1, 1'b1, 3, 1'b0);
            chk($sformatf("after_reset.tick%0d.text_on", k), 64'(tif.text_on), (k == 4) ? 64'd1 : 64'd0);
            chk($sformatf("after_reset.tick%0d.video_on_o", k), 64'(tif.video_on_o), (k == 4) ? 64'd1 : 64'd0);
        end
        chk("after_reset.text_rgb", 64'(tif.text_rgb), 64'h0FFF);

        // hsync pulse over hcount 656..751 must come out 4 ticks later, same width.
        lows = 0;
        for (int k = 0; k < 131; k++) begin
            logic hs;
            hs = (k < 128) ? !((640 + k >= 656) && (640 + k <= 751)) : 1'b1;
            hs_exp.push_back(hs);
            step(10'(640 + (k % 128)), 10'd100, 1'b0, hs, 1'b1, 3, 1'b0);
            if (k >= 3) begin
                chk($sformatf("hsync[%0d]", 640 + k - 3), 64'(tif.hsync_o), 64'(hs_exp[k-3]));
                if (tif.hsync_o == 1'b0) lows++;
            end
        end
        chk("hsync.width", 64'(lows), 64'd96);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
